// File: rtl/rangefinder_pkg.sv
// Shared types and constants for the rangefinder plot front-end.
// State encoding, step/watchdog widths and the printable-ASCII window for range bytes.
package rangefinder_pkg;

    localparam int STEP_W = 11;
    localparam int WDOG_W = 16;

    localparam logic [7:0] ASCII_LO = 8'h30;
    localparam logic [7:0] ASCII_HI = 8'h6F;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        HDR,
        HI,
        LO,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    function automatic logic is_ascii(input logic [7:0] b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Progress watchdog for stream-fed controllers: counts enabled cycles without a kick.
// expire is combinational from the count, so it never depends on the same cycle's kick.
module seq_watchdog
    import rangefinder_pkg::*;
#(
    parameter int WIDTH = WDOG_W,
    parameter int LIMIT = 65535
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic kick,
    output logic expire
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!en || kick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // cnt_q holds the number of idle cycles already spent, so the LIMIT-th one fires.
    assign expire = en && (cnt_q == WIDTH'(LIMIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/scan_sequencer.sv
// Scan controller: clears the frame buffer, drops header bytes, pairs range bytes and issues one plot per step.
// Optional SCAN_SKIP_INVALID_EN drops pairs holding bytes outside the ASCII range window instead of plotting them.
module scan_sequencer
    import rangefinder_pkg::*;
#(
    parameter int STEPS      = 682,
    parameter int SKIP_BYTES = 0,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        scan_start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        clear_req,
    input  logic        clear_done,
    output logic        plot_enable,
    output logic [15:0] plot_data,
    output logic [10:0] plot_step,
    input  logic        plot_done,
    output logic        scan_active,
    output logic        scan_done,
    output logic        timeout_err,
    output logic [10:0] points_plotted
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);
    localparam logic [8:0]        SKIP_N    = 9'(SKIP_BYTES);

    state_t              state_q, state_d, adv_state;
    logic [STEP_W-1:0]   plot_step_q, plot_step_d, adv_step;
    logic [STEP_W-1:0]   points_q, points_d;
    logic [7:0]          hdr_cnt_q, hdr_cnt_d;
    logic [15:0]         plot_data_q, plot_data_d;
    logic                timeout_err_q, timeout_err_d;
    logic                clear_req_q, clear_req_d;
    logic                plot_enable_q, plot_enable_d;
    logic                scan_done_q, scan_done_d;
    logic                scan_active_q, scan_active_d;
    logic                xfer, wd_en, wd_kick, wd_expire;

    assign rx_ready = (state_q == HDR) || (state_q == HI) || (state_q == LO);
    assign xfer     = rx_valid && rx_ready;
    assign wd_en    = (state_q == CLEAR) || (state_q == HDR) || (state_q == HI) ||
                      (state_q == LO) || (state_q == WAIT);
    assign wd_kick  = xfer || (state_d != state_q);

    seq_watchdog #(
        .WIDTH (WDOG_W),
        .LIMIT (TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .en     (wd_en),
        .kick   (wd_kick),
        .expire (wd_expire)
    );

    // Step advance shared by a completed plot and a skipped pair.
    always_comb begin
        adv_state = HI;
        adv_step  = plot_step_q + STEP_W'(1);
        if (plot_step_q == LAST_STEP) begin
            adv_state = DONE;
            adv_step  = plot_step_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        plot_step_d   = plot_step_q;
        points_d      = points_q;
        hdr_cnt_d     = hdr_cnt_q;
        plot_data_d   = plot_data_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (scan_start) begin
                    state_d       = CLEAR;
                    plot_step_d   = '0;
                    points_d      = '0;
                    hdr_cnt_d     = '0;
                    timeout_err_d = 1'b0;
                end
            end
            CLEAR: begin
                if (clear_done) begin
                    state_d = (SKIP_BYTES > 0) ? HDR : HI;
                end
            end
            HDR: begin
                if (xfer) begin
                    hdr_cnt_d = hdr_cnt_q + 8'd1;
                    if (({1'b0, hdr_cnt_q} + 9'd1) == SKIP_N) begin
                        state_d = HI;
                    end
                end
            end
            HI: begin
                if (xfer) begin
                    plot_data_d[15:8] = rx_data;
                    state_d           = LO;
                end
            end
            LO: begin
                if (xfer) begin
                    plot_data_d[7:0] = rx_data;
`ifdef SCAN_SKIP_INVALID_EN
                    if (is_ascii(plot_data_q[15:8]) && is_ascii(rx_data)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d     = adv_state;
                        plot_step_d = adv_step;
                    end
`else
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                points_d = points_q + STEP_W'(1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (plot_done) begin
                    state_d     = adv_state;
                    plot_step_d = adv_step;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A stalled handshake abandons the scan without reporting completion.
        if (wd_expire) begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
        end
    end

    always_comb begin
        clear_req_d   = (state_d == CLEAR);
        plot_enable_d = (state_d == ISSUE);
        scan_done_d   = (state_d == DONE);
        scan_active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            plot_step_q   <= '0;
            points_q      <= '0;
            hdr_cnt_q     <= '0;
            plot_data_q   <= '0;
            timeout_err_q <= 1'b0;
            clear_req_q   <= 1'b0;
            plot_enable_q <= 1'b0;
            scan_done_q   <= 1'b0;
            scan_active_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            plot_step_q   <= plot_step_d;
            points_q      <= points_d;
            hdr_cnt_q     <= hdr_cnt_d;
            plot_data_q   <= plot_data_d;
            timeout_err_q <= timeout_err_d;
            clear_req_q   <= clear_req_d;
            plot_enable_q <= plot_enable_d;
            scan_done_q   <= scan_done_d;
            scan_active_q <= scan_active_d;
        end
    end

    assign clear_req      = clear_req_q;
    assign plot_enable    = plot_enable_q;
    assign plot_data      = plot_data_q;
    assign plot_step      = plot_step_q;
    assign scan_active    = scan_active_q;
    assign scan_done      = scan_done_q;
    assign timeout_err    = timeout_err_q;
    assign points_plotted = points_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: two instances (no header / 3-byte header), byte source and plotter model.
module tb_scan_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a_cmd, start_b_cmd, inj_start, start_a;
    logic        clear_done, plot_done, rx_valid, xfer_pend;
    logic [7:0]  rx_data;
    logic        sel, auto_done;
    int          inj_step;

    logic        rx_ready_a, clear_req_a, plot_enable_a, scan_active_a, scan_done_a, timeout_err_a;
    logic [15:0] plot_data_a;
    logic [10:0] plot_step_a, points_a;
    logic        rx_ready_b, clear_req_b, plot_enable_b, scan_active_b, scan_done_b, timeout_err_b;
    logic [15:0] plot_data_b;
    logic [10:0] plot_step_b, points_b;

    logic        rx_ready_m, plot_enable_m, scan_done_m;
    logic [15:0] plot_data_m;
    logic [10:0] plot_step_m;

    logic [7:0]  src_buf [64];
    int          src_len, src_idx, src_nxt, dly, done_cnt;
    logic [15:0] en_data [$];
    logic [10:0] en_step [$];
    logic        en_rxv [$];
    logic        en_rdy [$];

    int n_tests, n_fail;

    assign start_a       = start_a_cmd | inj_start;
    assign rx_ready_m    = sel ? rx_ready_b    : rx_ready_a;
    assign plot_enable_m = sel ? plot_enable_b : plot_enable_a;
    assign scan_done_m   = sel ? scan_done_b   : scan_done_a;
    assign plot_data_m   = sel ? plot_data_b   : plot_data_a;
    assign plot_step_m   = sel ? plot_step_b   : plot_step_a;

    assign rx_valid = (src_idx < src_len);
    assign rx_data  = src_buf[src_idx[5:0]];
    assign src_nxt  = src_idx + (xfer_pend ? 1 : 0);

    scan_sequencer #(.STEPS(4), .SKIP_BYTES(0), .TIMEOUT(50)) dut_a (
        .clk(clk), .reset(reset), .scan_start(start_a),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_a),
        .clear_req(clear_req_a), .clear_done(clear_done),
        .plot_enable(plot_enable_a), .plot_data(plot_data_a), .plot_step(plot_step_a),
        .plot_done(plot_done), .scan_active(scan_active_a), .scan_done(scan_done_a),
        .timeout_err(timeout_err_a), .points_plotted(points_a)
    );

    scan_sequencer #(.STEPS(3), .SKIP_BYTES(3), .TIMEOUT(50)) dut_b (
        .clk(clk), .reset(reset), .scan_start(start_b_cmd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready_b),
        .clear_req(clear_req_b), .clear_done(clear_done),
        .plot_enable(plot_enable_b), .plot_data(plot_data_b), .plot_step(plot_step_b),
        .plot_done(plot_done), .scan_active(scan_active_b), .scan_done(scan_done_b),
        .timeout_err(timeout_err_b), .points_plotted(points_b)
    );

    // Byte source, plotter responder and enable recorder, all on the falling edge.
    initial begin
        src_idx = 0; xfer_pend = 1'b0; plot_done = 1'b0;
        dly = 0; done_cnt = 0; inj_start = 1'b0;
    end

    always @(negedge clk) begin
        src_idx   <= src_nxt;
        xfer_pend <= (src_nxt < src_len) && rx_ready_m;
        plot_done <= 1'b0;
        if (dly > 1) begin
            dly <= dly - 1;
        end else if (dly == 1) begin
            dly       <= 0;
            plot_done <= 1'b1;
        end
        if (plot_enable_m) begin
            en_data.push_back(plot_data_m);
            en_step.push_back(plot_step_m);
            en_rxv.push_back(rx_valid);
            en_rdy.push_back(rx_ready_m);
            if (auto_done) dly <= 3;
        end
        if (inj_start) begin
            inj_start <= 1'b0;
        end else if (plot_enable_m && !sel && (int'(plot_step_m) == inj_step)) begin
            inj_start <= 1'b1;
        end
        if (scan_done_m) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [7:0] b);
        src_buf[src_len[5:0]] = b;
        src_len++;
    endtask

    task automatic pulse_clear_done();
        clear_done = 1'b1;
        tick();
        clear_done = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget);
        int i;
        i = 0;
        while (done_cnt == base && i < budget) begin
            tick();
            i++;
        end
        check("scan_done_seen", 32'(done_cnt != base), 32'd1);
    endtask

    logic [15:0] exp1_data [4] = '{16'h3132, 16'h3334, 16'h3536, 16'h3738};
`ifdef SCAN_SKIP_INVALID_EN
    localparam int   B_N = 2;
    logic [15:0] exp2_data [B_N] = '{16'h3031, 16'h3233};
    logic [10:0] exp2_step [B_N] = '{11'd0, 11'd2};
`else
    localparam int   B_N = 3;
    logic [15:0] exp2_data [B_N] = '{16'h3031, 16'h2020, 16'h3233};
    logic [10:0] exp2_step [B_N] = '{11'd0, 11'd1, 11'd2};
`endif

    initial begin
        int base_en, base_done, n;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; sel = 1'b0; auto_done = 1'b0; inj_step = -1;
        start_a_cmd = 1'b0; start_b_cmd = 1'b0; clear_done = 1'b0; src_len = 0;
        repeat (3) tick();

        check("rst_a_flags", 32'({rx_ready_a, clear_req_a, plot_enable_a, scan_active_a, scan_done_a, timeout_err_a}), 32'd0);
        check("rst_a_cnt", 32'({points_a, plot_step_a}), 32'd0);
        check("rst_a_data", 32'(plot_data_a), 32'd0);
        check("rst_b_flags", 32'({rx_ready_b, clear_req_b, plot_enable_b, scan_active_b, scan_done_b, timeout_err_b}), 32'd0);
        reset = 1'b0;
        tick();

        // Full scan without header; bytes pending throughout, stray scan_start during WAIT of step 1.
        for (int i = 0; i < 8; i++) push(8'h31 + 8'(i));
        sel = 1'b0; auto_done = 1'b1; inj_step = 1;
        base_en = en_data.size(); base_done = done_cnt;
        start_a_cmd = 1'b1; tick(); start_a_cmd = 1'b0;
        check("a_active", 32'(scan_active_a), 32'd1);
        check("a_clear_req", 32'(clear_req_a), 32'd1);
        check("a_rdy_in_clear", 32'(rx_ready_a), 32'd0);
        repeat (9) tick();
        pulse_clear_done();
        check("a_clear_drop", 32'(clear_req_a), 32'd0);
        check("a_rdy_in_hi", 32'(rx_ready_a), 32'd1);
        wait_done(base_done, 200);
        repeat (2) tick();
        check("a_enables", 32'(en_data.size() - base_en), 32'd4);
        if (en_data.size() >= base_en + 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("a_data%0d", i), 32'(en_data[base_en + i]), 32'(exp1_data[i]));
                check($sformatf("a_step%0d", i), 32'(en_step[base_en + i]), i);
            end
            check("a_hold_valid", 32'(en_rxv[base_en]), 32'd1);
            check("a_hold_ready", 32'(en_rdy[base_en]), 32'd0);
        end
        check("a_points", 32'(points_a), 32'd4);
        check("a_final_step", 32'(plot_step_a), 32'd3);
        check("a_done_count", 32'(done_cnt - base_done), 32'd1);
        check("a_idle", 32'(scan_active_a), 32'd0);
        inj_step = -1;

        // Three header bytes dropped before the first pair; middle pair is out of ASCII range.
        sel = 1'b1;
        push(8'hAA); push(8'hBB); push(8'hCC);
        push(8'h30); push(8'h31); push(8'h20); push(8'h20); push(8'h32); push(8'h33);
        base_en = en_data.size(); base_done = done_cnt;
        start_b_cmd = 1'b1; tick(); start_b_cmd = 1'b0;
        repeat (2) tick();
        pulse_clear_done();
        check("b_rdy_in_hdr", 32'(rx_ready_b), 32'd1);
        wait_done(base_done, 200);
        repeat (2) tick();
        check("b_enables", 32'(en_data.size() - base_en), B_N);
        if (en_data.size() >= base_en + B_N) begin
            for (int i = 0; i < B_N; i++) begin
                check($sformatf("b_data%0d", i), 32'(en_data[base_en + i]), 32'(exp2_data[i]));
                check($sformatf("b_step%0d", i), 32'(en_step[base_en + i]), 32'(exp2_step[i]));
            end
        end
        check("b_points", 32'(points_b), B_N);
        check("b_final_step", 32'(plot_step_b), 32'd2);
        check("b_done_count", 32'(done_cnt - base_done), 32'd1);

        // plot_done withheld: WAIT must time out after exactly 50 cycles.
        sel = 1'b0; auto_done = 1'b0;
        push(8'h41); push(8'h42);
        base_en = en_data.size(); base_done = done_cnt;
        start_a_cmd = 1'b1; tick(); start_a_cmd = 1'b0;
        tick();
        pulse_clear_done();
        n = 0;
        while (en_data.size() == base_en && n < 20) begin
            tick();
            n++;
        end
        check("to_enable_seen", 32'(en_data.size() - base_en), 32'd1);
        n = 0;
        while (scan_active_a && n < 200) begin
            tick();
            n++;
        end
        check("to_wait_cycles", n, 32'd50);
        check("to_err", 32'(timeout_err_a), 32'd1);
        check("to_clear_req", 32'(clear_req_a), 32'd0);
        check("to_no_done", 32'(done_cnt - base_done), 32'd0);
        check("to_points", 32'(points_a), 32'd1);

        // A new scan clears the sticky flag; left in CLEAR it times out again.
        start_a_cmd = 1'b1; tick(); start_a_cmd = 1'b0;
        check("restart_err_clr", 32'(timeout_err_a), 32'd0);
        check("restart_active", 32'(scan_active_a), 32'd1);
        n = 0;
        while (scan_active_a && n < 200) begin
            tick();
            n++;
        end
        check("to_clear_cycles", n, 32'd50);
        check("to_clear_err", 32'(timeout_err_a), 32'd1);
        check("to_clear_req_low", 32'(clear_req_a), 32'd0);

        // Asynchronous reset in the middle of the header phase.
        sel = 1'b1;
        start_b_cmd = 1'b1; tick(); start_b_cmd = 1'b0;
        pulse_clear_done();
        check("mid_rdy_hdr", 32'(rx_ready_b), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_flags", 32'({rx_ready_b, scan_active_b, clear_req_b, plot_enable_b}), 32'd0);
        check("mid_rst_data", 32'(plot_data_b), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Front-end controller for the rangefinder plot datapath. It takes the rangefinder's byte stream, clears the VGA frame buffer at the start of each scan, and assembles byte pairs into 16-bit ASCII range words. It then issues one plot request per angular step, with a step index and a completion handshake. It sits between the UART/SPI byte receiver and the plotter, and replaces free-running enable pulses and button-driven clears.

Parameters:
STEPS, 682, number of angular steps per scan (valid range 1..2047)
SKIP_BYTES, 0, header bytes discarded after the clear, before the first range pair (0..255)
TIMEOUT, 65535, cycles without progress in any wait state before abort (16-bit)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
scan_start  in  1  single-cycle pulse that begins a scan; ignored unless in IDLE
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid; a byte transfers when rx_valid && rx_ready
rx_ready  out  1  sequencer accepts a byte this cycle
clear_req  out  1  level request to the plotter to clear the frame buffer
clear_done  in  1  single-cycle pulse: clear complete
plot_enable  out  1  single-cycle pulse: plot plot_data at plot_step
plot_data  out  16  range word; first byte in [15:8], second byte in [7:0]
plot_step  out  11  step index of the current point
plot_done  in  1  single-cycle pulse: plotter finished the current point
scan_active  out  1  high in every state except IDLE
scan_done  out  1  single-cycle pulse when a scan completes normally
timeout_err  out  1  sticky abort flag; cleared by the next accepted scan_start
points_plotted  out  11  count of plot_enable pulses in the current/last scan

Behaviour:
- On reset, all outputs are 0, the state is IDLE, and all internal counters are 0.
- FSM states: IDLE, CLEAR, HDR, HI, LO, ISSUE, WAIT, DONE.
- IDLE:
  - scan_start -> CLEAR.
  - The same edge zeroes plot_step, points_plotted, the header counter and timeout_err.
- CLEAR:
  - clear_req = 1.
  - clear_done -> HDR if SKIP_BYTES > 0, else HI.
  - clear_req drops in the cycle after clear_done is sampled.
- HDR:
  - rx_ready = 1.
  - Each transfer increments the header counter.
  - On the transfer that makes the count equal SKIP_BYTES -> HI.
- HI:
  - rx_ready = 1.
  - On transfer, rx_data is captured into plot_data[15:8] -> LO.
- LO:
  - rx_ready = 1.
  - On transfer, rx_data is captured into plot_data[7:0] -> ISSUE.
- ISSUE:
  - rx_ready = 0.
  - plot_enable = 1 for exactly this one cycle; points_plotted increments.
  - -> WAIT.
  - plot_data and plot_step stay stable from ISSUE until WAIT exits.
- WAIT:
  - plot_done -> if plot_step == STEPS-1 then DONE, else plot_step increments and the next state is HI.
  - A plot_done asserted in the same cycle as plot_enable is ignored.
- DONE:
  - scan_done = 1 for one cycle -> IDLE.
  - plot_step holds its final value.
- rx_ready is combinational from state only. Bytes presented in other states are not consumed and stay pending at the source.
- Watchdog:
  - A 16-bit counter runs in CLEAR, HDR, HI, LO and WAIT.
  - It resets on any state change, any byte transfer, and in IDLE.
  - Reaching TIMEOUT -> IDLE with timeout_err = 1, clear_req = 0, and no scan_done.
- Simultaneous events:
  - scan_start in any non-IDLE state is ignored.
  - clear_done or plot_done outside CLEAR/WAIT is ignored.
- Reset mid-scan aborts immediately to IDLE with all outputs 0.
- Throughput: minimum 4 cycles per point (HI, LO, ISSUE, WAIT) when rx_valid is held high and plot_done returns on the first WAIT cycle.

Optional Feature:
- Macro: SCAN_SKIP_INVALID_EN.
- When defined:
  - In LO, if the captured pair has either byte < 8'h30 or > 8'h6F, the point is skipped.
  - A skipped point produces no ISSUE and no WAIT; the FSM goes straight to the step advance/DONE decision.
  - plot_step still advances for a skipped point; points_plotted does not.
- When undefined, every pair is issued unconditionally.

Decomposition:
- Package rangefinder_pkg:
  - State enum.
  - STEP_W = 11.
  - ASCII_LO = 8'h30, ASCII_HI = 8'h6F.
  - Watchdog width 16.
- One sub-module: seq_watchdog (counter, kick/enable inputs, expire output), shared with other stream-fed blocks.
- Step, header and point counters stay inline.

Test Plan:
- STEPS=4, SKIP_BYTES=0: scan_start; clear_done after 10 cycles; bytes 31 32 33 34 35 36 37 38; plot_done 3 cycles after each enable -> 4 enables with plot_step 0..3 and plot_data 3132, 3334, 3536, 3738; scan_done once; points_plotted=4.
- SKIP_BYTES=3: bytes AA BB CC 30 31 -> first plot_data=3031, first plot_step=0; the header bytes never appear on plot_data.
- scan_start pulsed during WAIT -> ignored; scan completes normally.
- TIMEOUT=50, plot_done withheld -> IDLE after 50 cycles; timeout_err=1, no scan_done; the next scan_start clears timeout_err.
- rx_valid high during ISSUE/WAIT -> rx_ready=0, byte held, then consumed in HI.
- SCAN_SKIP_INVALID_EN, STEPS=3: pairs 3031, 2020, 3233 -> enables at steps 0 and 2 only; points_plotted=2; scan_done asserted.
